// File: rtl/depthwise_pkg.sv
// depthwise_pkg
//   Shared constants and types for the depthwise 3x3 sequencer.
//   K     : kernel edge length
//   TAPS  : taps per window (K*K)
//   state_e : sequencer states
package depthwise_pkg;

    localparam int K    = 3;
    localparam int TAPS = K * K;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dw_delay_line.sv
// dw_delay_line
//   LAT-deep shift register carrying {valid, addr} from the tap_last strobe
//   to the point where the datapath result is valid. It never stalls.
//   Ports:
//     clk_i   : clock
//     rst_ni  : synchronous active-low reset, clears every stage
//     vld_i   : valid into stage 0
//     addr_i  : address into stage 0
//     vld_o   : valid out of the last stage
//     addr_o  : address out of the last stage (zero when vld_o is low)
//     pend_o  : a valid entry is still travelling behind the output stage
module dw_delay_line #(
    parameter int LAT = 2,
    parameter int AW  = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vld_i,
    input  logic [AW-1:0] addr_i,
    output logic          vld_o,
    output logic [AW-1:0] addr_o,
    output logic          pend_o
);

    logic [LAT-1:0] vld_q;
    logic [AW-1:0]  addr_q [LAT];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            // addresses ride only with a valid entry so the output idles at zero
            addr_q[0] <= vld_i ? addr_i : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend_o = pend_o | vld_q[i];
    end

    assign vld_o  = vld_q[LAT-1];
    assign addr_o = addr_q[LAT-1];

endmodule

// File: rtl/depthwise_seq.sv
// depthwise_seq
//   Sequencer for the depthwise 3x3 convolution datapath. Walks
//   ch -> orow -> ocol -> ky -> kx and issues per-tap buffer addresses and
//   MAC strobes; the output write strobe/address follow through a
//   PIPE_LAT-deep delay line.
//   Build option: define DW_PAD_EN for "same" padding (window origin at
//   (orow-1, ocol-1), out-of-image taps flagged by tap_zero).
//   Ports:
//     clk, rst (sync, active-low), start, hold
//     busy, done
//     in_addr, w_addr, tap_valid, tap_first, tap_last, tap_zero
//     out_wr, out_addr
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing taps (frozen while hold)
//   DRAIN | last tap issued, waiting for the final out_wr
//   DONE  | one-cycle done pulse
module depthwise_seq
    import depthwise_pkg::*;
#(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int CH       = 3,
    parameter int ADDR_W   = 12,
    parameter int WADDR_W  = 5,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  in_addr,
    output logic [WADDR_W-1:0] w_addr,
    output logic               tap_valid,
    output logic               tap_first,
    output logic               tap_last,
    output logic               tap_zero,
    output logic               out_wr,
    output logic [ADDR_W-1:0]  out_addr
);

`ifdef DW_PAD_EN
    localparam int OH = IMG_H;
    localparam int OW = IMG_W;
`else
    localparam int OH = IMG_H - 2;
    localparam int OW = IMG_W - 2;
`endif
    localparam int CW = $clog2(CH + 1);
    localparam int RW = $clog2(OH + 1);
    localparam int XW = $clog2(OW + 1);

    localparam logic [CW-1:0]      CH_LAST    = CW'(CH - 1);
    localparam logic [RW-1:0]      ROW_LAST   = RW'(OH - 1);
    localparam logic [XW-1:0]      COL_LAST   = XW'(OW - 1);
    localparam logic [1:0]         K_LAST     = 2'(K - 1);
    localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  CH_STRIDE  = ADDR_W'(IMG_W * IMG_H);
    localparam logic [WADDR_W-1:0] W_STRIDE   = WADDR_W'(TAPS);

    state_e state_q, state_d;

    logic [CW-1:0]      ch_q, ch_d;
    logic [RW-1:0]      orow_q, orow_d;
    logic [XW-1:0]      ocol_q, ocol_d;
    logic [1:0]         ky_q, ky_d, kx_q, kx_d;
    logic [3:0]         wk_q, wk_d;          // tap index within the window
    logic [WADDR_W-1:0] wbase_q, wbase_d;    // ch*TAPS
    logic [ADDR_W-1:0]  chb_q, chb_d;        // ch*IMG_W*IMG_H
    logic [ADDR_W-1:0]  rowb_q, rowb_d;      // chb + orow*IMG_W
    logic [ADDR_W-1:0]  win_q, win_d;        // rowb + ocol
    logic [ADDR_W-1:0]  roff_q, roff_d;      // ky*IMG_W
    logic [ADDR_W-1:0]  oidx_q, oidx_d;      // window index == output address

    logic              last_win, oob, dl_pend;
    logic [ADDR_W-1:0] addr_raw;

    dw_delay_line #(.LAT(PIPE_LAT), .AW(ADDR_W)) u_dl (
        .clk_i  (clk),
        .rst_ni (rst),
        .vld_i  (tap_last),
        .addr_i (oidx_q),
        .vld_o  (out_wr),
        .addr_o (out_addr),
        .pend_o (dl_pend)
    );

    assign last_win = (ch_q == CH_LAST) && (orow_q == ROW_LAST) && (ocol_q == COL_LAST);

`ifdef DW_PAD_EN
    // origin sits one row and one column up-left, so subtract IMG_W+1;
    // wrap-around only happens for taps that oob already zeroes
    assign addr_raw = win_q + roff_q + ADDR_W'(kx_q) - ADDR_W'(IMG_W + 1);
    assign oob = ((orow_q == '0) && (ky_q == 2'd0)) || ((orow_q == ROW_LAST) && (ky_q == K_LAST))
              || ((ocol_q == '0) && (kx_q == 2'd0)) || ((ocol_q == COL_LAST) && (kx_q == K_LAST));
`else
    assign addr_raw = win_q + roff_q + ADDR_W'(kx_q);
    assign oob      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            wk_q    <= '0;
            wbase_q <= '0;
            chb_q   <= '0;
            rowb_q  <= '0;
            win_q   <= '0;
            roff_q  <= '0;
            oidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            wk_q    <= wk_d;
            wbase_q <= wbase_d;
            chb_q   <= chb_d;
            rowb_q  <= rowb_d;
            win_q   <= win_d;
            roff_q  <= roff_d;
            oidx_q  <= oidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (tap_last && last_win) state_d = DRAIN;
            DRAIN:   if (out_wr && !dl_pend) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loop counters; held at zero outside RUN so every pass starts clean.
    always_comb begin
        ch_d    = ch_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        wk_d    = wk_q;
        wbase_d = wbase_q;
        chb_d   = chb_q;
        rowb_d  = rowb_q;
        win_d   = win_q;
        roff_d  = roff_q;
        oidx_d  = oidx_q;
        if (state_q != RUN) begin
            ch_d    = '0;
            orow_d  = '0;
            ocol_d  = '0;
            ky_d    = '0;
            kx_d    = '0;
            wk_d    = '0;
            wbase_d = '0;
            chb_d   = '0;
            rowb_d  = '0;
            win_d   = '0;
            roff_d  = '0;
            oidx_d  = '0;
        end else if (tap_valid) begin
            wk_d = wk_q + 4'd1;
            if (kx_q != K_LAST) begin
                kx_d = kx_q + 2'd1;
            end else begin
                kx_d = '0;
                if (ky_q != K_LAST) begin
                    ky_d   = ky_q + 2'd1;
                    roff_d = roff_q + ROW_STRIDE;
                end else begin
                    ky_d   = '0;
                    roff_d = '0;
                    wk_d   = '0;
                    oidx_d = oidx_q + ADDR_W'(1);
                    if (ocol_q != COL_LAST) begin
                        ocol_d = ocol_q + XW'(1);
                        win_d  = win_q + ADDR_W'(1);
                    end else begin
                        ocol_d = '0;
                        if (orow_q != ROW_LAST) begin
                            orow_d = orow_q + RW'(1);
                            rowb_d = rowb_q + ROW_STRIDE;
                            win_d  = rowb_q + ROW_STRIDE;
                        end else begin
                            orow_d  = '0;
                            ch_d    = ch_q + CW'(1);
                            chb_d   = chb_q + CH_STRIDE;
                            rowb_d  = chb_q + CH_STRIDE;
                            win_d   = chb_q + CH_STRIDE;
                            wbase_d = wbase_q + W_STRIDE;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        busy      = (state_q == RUN) || (state_q == DRAIN);
        done      = (state_q == DONE);
        tap_valid = (state_q == RUN) && !hold;
        tap_first = tap_valid && (ky_q == 2'd0) && (kx_q == 2'd0);
        tap_last  = tap_valid && (ky_q == K_LAST) && (kx_q == K_LAST);
        tap_zero  = tap_valid && oob;
        in_addr   = oob ? '0 : addr_raw;
        w_addr    = wbase_q + WADDR_W'(wk_q);
    end

endmodule

// File: tb/tb_depthwise_seq.sv
module tb_depthwise_seq;

    localparam int IMG_W    = 32;
    localparam int IMG_H    = 32;
    localparam int CH       = 3;
    localparam int ADDR_W   = 12;
    localparam int WADDR_W  = 5;
    localparam int PIPE_LAT = 2;
`ifdef DW_PAD_EN
    localparam int OH  = IMG_H;
    localparam int OW  = IMG_W;
    localparam int PAD = 1;
`else
    localparam int OH  = IMG_H - 2;
    localparam int OW  = IMG_W - 2;
    localparam int PAD = 0;
`endif
    localparam int NWIN = CH * OH * OW;
    localparam int NTAP = NWIN * 9;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               hold = 1'b0;
    logic               busy, done;
    logic [ADDR_W-1:0]  in_addr;
    logic [WADDR_W-1:0] w_addr;
    logic               tap_valid, tap_first, tap_last, tap_zero;
    logic               out_wr;
    logic [ADDR_W-1:0]  out_addr;

    always #5 clk = ~clk;

    depthwise_seq #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .ADDR_W(ADDR_W),
        .WADDR_W(WADDR_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy), .done(done),
        .in_addr(in_addr), .w_addr(w_addr),
        .tap_valid(tap_valid), .tap_first(tap_first), .tap_last(tap_last), .tap_zero(tap_zero),
        .out_wr(out_wr), .out_addr(out_addr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: a pass is a list of NTAP taps issued in order,
    // one per cycle that is not held; each ninth tap schedules a write.
    int cyc       = 0;
    bit m_idle    = 1;
    bit m_run     = 0;
    int m_tap     = 0;
    int m_done_at = -1;
    int q_due[$];
    int q_addr[$];

    int s0, first_out, last_out, last_out_addr, out_cnt, hold_run, done_cnt, done_dut_at;

    task automatic step(input bit h, input bit s);
        bit ev, eo, zero;
        int n, k, ky, kx, ch, r, c, y, x, want_addr;
        @(negedge clk);
        hold  = h;
        start = s;
        #1;
        ev = m_run && !h;
        check("tap_valid", int'(tap_valid), int'(ev));
        if (ev) begin
            n  = m_tap / 9;
            k  = m_tap % 9;
            ky = k / 3;
            kx = k % 3;
            ch = n / (OH * OW);
            r  = (n / OW) % OH;
            c  = n % OW;
            y  = r + ky - PAD;
            x  = c + kx - PAD;
            zero = (y < 0) || (y >= IMG_H) || (x < 0) || (x >= IMG_W);
            want_addr = zero ? 0 : ch * IMG_W * IMG_H + y * IMG_W + x;
            check("in_addr", int'(in_addr), want_addr);
            check("w_addr", int'(w_addr), ch * 9 + k);
            check("tap_first", int'(tap_first), int'(k == 0));
            check("tap_last", int'(tap_last), int'(k == 8));
            check("tap_zero", int'(tap_zero), int'(zero));
`ifdef DW_PAD_EN
            if (m_tap < 9)
                check("w0_tap_zero", int'(tap_zero), int'(k == 0 || k == 1 || k == 2 || k == 3 || k == 6));
            if (m_tap == 4) check("w0_tap4_in_addr", int'(in_addr), 0);
`else
            if (m_tap == 0)        check("first_in_addr", int'(in_addr), 0);
            if (m_tap == 8)        check("tap8_in_addr", int'(in_addr), 66);
            if (m_tap == 8)        check("tap8_w_addr", int'(w_addr), 8);
            if (m_tap == 900 * 9)  check("ch1_in_addr", int'(in_addr), 1024);
            if (m_tap == 900 * 9)  check("ch1_w_addr", int'(w_addr), 9);
            if (m_tap == NTAP - 1) check("last_in_addr", int'(in_addr), 3071);
            if (m_tap == NTAP - 1) check("last_w_addr", int'(w_addr), 26);
`endif
        end
        eo = (q_due.size() > 0) && (q_due[0] == cyc);
        check("out_wr", int'(out_wr), int'(eo));
        if (eo) begin
            check("out_addr", int'(out_addr), q_addr[0]);
            out_cnt++;
            last_out      = cyc;
            last_out_addr = int'(out_addr);
            if (first_out < 0) first_out = cyc;
        end
        check("done", int'(done), int'(cyc == m_done_at));
        if (done) begin
            done_cnt++;
            done_dut_at = cyc;
        end
        check("busy", int'(busy), int'(!m_idle && cyc != m_done_at));

        if (m_run && h) hold_run++;
        if (ev) begin
            if (k == 8) begin
                q_due.push_back(cyc + PIPE_LAT);
                q_addr.push_back(n);
            end
            m_tap++;
            if (m_tap == NTAP) m_run = 0;
        end
        if (eo) begin
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
            if (!m_run && m_tap == NTAP && q_due.size() == 0 && !m_idle) m_done_at = cyc + 1;
        end
        if (cyc == m_done_at) begin
            m_idle = 1;
        end else if (m_idle && s) begin
            m_idle      = 0;
            m_run       = 1;
            m_tap       = 0;
            s0          = cyc;
            first_out   = -1;
            last_out    = -1;
            out_cnt     = 0;
            hold_run    = 0;
            done_cnt    = 0;
            done_dut_at = -1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        hold  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_addr", int'(in_addr), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_tap_valid", int'(tap_valid), 0);
        check("rst_tap_first", int'(tap_first), 0);
        check("rst_tap_last", int'(tap_last), 0);
        check("rst_tap_zero", int'(tap_zero), 0);
        check("rst_out_wr", int'(out_wr), 0);
        check("rst_out_addr", int'(out_addr), 0);
        m_idle    = 1;
        m_run     = 0;
        m_tap     = 0;
        m_done_at = -1;
        q_due.delete();
        q_addr.delete();
    endtask

    task automatic run_pass();
        int  n, rel;
        bit  h, s;
        step(1'b0, 1'b1);
        n = 0;
        while (!m_idle && n < 2 * NTAP + 1000) begin
            rel = cyc - s0;
            h = 1'b0;
            if (rel >= 40 && rel < 45)  h = 1'b1;
            else if (rel > 300)          h = ($urandom_range(0, 31) == 0);
            s = (cyc == m_done_at) ? 1'b1 : ($urandom_range(0, 499) == 0);
            step(h, s);
            n++;
        end
        if (!m_idle) check("pass_timeout", 1, 0);
        check("out_count", out_cnt, NWIN);
        check("first_out_cycle", first_out - s0, 9 + PIPE_LAT);
        check("last_out_cycle", last_out - s0, NTAP + PIPE_LAT + hold_run);
        check("last_out_addr", last_out_addr, NWIN - 1);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_dut_at - s0, NTAP + PIPE_LAT + 1 + hold_run);
        repeat (5) step(1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        repeat (3) step(1'b0, 1'b0);

        run_pass();

        // interrupted pass: random hold and stray starts, then reset
        step(1'b0, 1'b1);
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
        do_reset();
        repeat (20) step(1'b0, 1'b0);

        run_pass();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/depthwise_seq.md
# depthwise_seq

Sequencer for the depthwise 3x3 convolution datapath. It walks the channels, output rows, output columns and kernel taps of one feature map, and generates read addresses for the input and weight buffers. It issues per-tap strobes to the depthwise MAC and produces the output write strobe and address once each window's result leaves the datapath. It sits between the feature and weight buffers and the depthwise datapath, and is kicked by the layer controller with a start pulse.

## Interface
- IMG_W, 32, input width in pixels
- IMG_H, 32, input height in pixels
- CH, 3, channel count; one 3x3 kernel per channel
- ADDR_W, 12, input and output buffer address width
- WADDR_W, 5, weight buffer address width
- PIPE_LAT, 2, cycles from a tap_last strobe to the accumulated result being valid at the datapath output (must be ≥1)
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse that begins one full-map pass; ignored while busy
- hold  in  1  freezes tap issue while high (for example, buffer not ready)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse, one cycle after the final out_wr
- in_addr  out  ADDR_W  input buffer read address for the current tap
- w_addr  out  WADDR_W  weight buffer read address for the current tap
- tap_valid  out  1  current tap is live; the MAC accumulates only when this is high
- tap_first  out  1  first tap (ky=0, kx=0) of a window; the MAC clears its accumulator
- tap_last  out  1  ninth tap of a window
- tap_zero  out  1  tap lies outside the image; the MAC uses 0 as the pixel (only with DW_PAD_EN)
- out_wr  out  1  datapath result is valid this cycle; write it to the output buffer
- out_addr  out  ADDR_W  output buffer write address paired with out_wr

## Operation
- States:
  - IDLE goes to RUN when start is high.
  - RUN goes to DRAIN after the tap_last of the final window is issued.
  - DRAIN goes to DONE when the final out_wr has been emitted.
  - DONE goes to IDLE unconditionally after 1 cycle; done is high only in DONE.
- Loop order, outermost first: ch in [0,CH), orow in [0,OH), ocol in [0,OW), ky in [0,3), kx in [0,3).
- Without padding: OH = IMG_H-2 and OW = IMG_W-2, giving 30x30 with the defaults.
- in_addr = ch·IMG_W·IMG_H + (orow+ky)·IMG_W + (ocol+kx).
- w_addr = ch·9 + ky·3 + kx.
- out_addr = ch·OW·OH + orow·OW + ocol.
- Address arithmetic uses multiply-free incremental counters. Row and channel bases advance by adding strides, with no combinational multipliers.
- While hold is high in RUN, tap_valid is 0 and all loop counters freeze. The out_wr delay line keeps shifting, because the datapath does not stall.
- The out_wr/out_addr delay line is PIPE_LAT stages long and loaded from tap_last.
- Reset values: state IDLE, all counters 0, and every output 0, including in_addr, w_addr and out_addr.
- Reset mid-pass: the pass is abandoned, the delay line is cleared, and no further out_wr or done is emitted.
- start while busy: ignored, with no effect on counters.
- start during DONE: ignored; a new start must arrive in IDLE.
- Unused address MSBs are zero-filled.

## Timing
- A start sampled at cycle 0 gives busy=1 and the first tap_valid at cycle 1.
- Without hold, taps are back-to-back: window n occupies cycles 9n+1 to 9n+9.
- Window n produces out_wr at cycle 9n+9+PIPE_LAT.
- Defaults: 2700 windows and 24300 taps; the last tap is at cycle 24300, the last out_wr at 24302, and done at 24303.
- Each cycle of hold adds exactly one cycle to every later event.

## Configuration
- DW_PAD_EN defined: "same" padding is enabled.
  - OH = IMG_H and OW = IMG_W; the window origin is (orow-1, ocol-1).
  - Taps outside [0,IMG_H) x [0,IMG_W) assert tap_zero and drive in_addr to 0.
  - Default totals are 3072 windows and 27648 taps.
- DW_PAD_EN undefined: valid-only convolution; tap_zero is tied to 0 and the boundary logic is not built.

## Structure
- The shared package depthwise_pkg holds the kernel constants (K=3, TAPS=9) and the state enum {IDLE, RUN, DRAIN, DONE}.
- The delay line is one sub-module, dw_delay_line: a PIPE_LAT-deep shift register carrying {valid, addr}.

## Test plan
- Reset then a start pulse, defaults, no hold:
  - first tap in_addr=0 and w_addr=0 with tap_first=1;
  - ninth tap in_addr=66 and w_addr=8 with tap_last=1;
  - first out_wr at cycle 11 with out_addr=0.
- Channel boundary: window 900, the first of ch1, starts with in_addr=1024 and w_addr=9; its out_addr is 900.
- Full pass: the last tap has in_addr=3071 and w_addr=26; the last out_wr has out_addr=2699 at cycle 24302; done=1 at cycle 24303 only; out_wr is counted exactly 2700 times.
- hold high for 5 cycles mid-window: tap_valid is 0 throughout, tap addresses resume unchanged, and every later event is shifted by exactly +5 cycles.
- rst low mid-pass, then a new start:
  - all outputs are 0 the cycle after reset, and no stale out_wr appears;
  - the new pass restarts at in_addr=0;
  - a start asserted while busy has no effect.
- DW_PAD_EN:
  - first window taps 0, 1, 2, 3 and 6 have tap_zero=1;
  - tap 4 has in_addr=0 with tap_zero=0;
  - 3072 out_wr in total, the last with out_addr=3071.
